cnt_stream_checker: RTL

CNT_STREAM_CHECKER -- requirements
Module: cnt_stream_checker

---
 rtl/cnt_stream_checker.sv | 106 ++++++++++
 1 files changed

// File: rtl/cnt_stream_checker.sv
// Locks onto an incrementing 8-bit count stream and counts mismatches once locked; outputs registered, one edge of latency, no backpressure.
// Define CNT_STREAM_CHECKER_STATS_EN to build the good_cnt statistics counter; otherwise good_cnt is tied to zero.
module cnt_stream_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  din,
  input  logic        din_valid,
  input  logic        clear,
  output logic        locked,
  output logic        err_flag,
  output logic [7:0]  err_cnt,
  output logic [15:0] good_cnt
);

  typedef enum logic [1:0] {IDLE, SYNC, LOCKED} state_t;

  state_t     state;
  logic [7:0] exp_q;
  logic [3:0] run;
  logic [3:0] miss;

  logic match;
  logic lock_hit;
  logic loss_hit;

  assign match    = (din == exp_q);
  assign lock_hit = ((run + 4'd1) == 4'(LOCK_CNT));
  assign loss_hit = ((miss + 4'd1) == 4'(LOSS_CNT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      exp_q    <= 8'd0;
      run      <= 4'd0;
      miss     <= 4'd0;
      locked   <= 1'b0;
      err_flag <= 1'b0;
      err_cnt  <= 8'd0;
    end else begin
      if (din_valid) begin
        case (state)
          IDLE: begin
            exp_q <= din + 8'd1;
            run   <= 4'd0;
            state <= SYNC;
          end
          SYNC: begin
            exp_q <= din + 8'd1;
            if (match) begin
              run <= run + 4'd1;
              if (lock_hit) begin
                state  <= LOCKED;
                locked <= 1'b1;
                miss   <= 4'd0;
              end
            end else begin
              run <= 4'd0;
            end
          end
          LOCKED: begin
            if (match) begin
              miss  <= 4'd0;
              exp_q <= din + 8'd1;
            end else begin
              err_flag <= 1'b1;
              if (err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
              miss <= miss + 4'd1;
              if (loss_hit) begin
                // Resync re-seeds from the offending sample rather than the old expectation.
                state  <= SYNC;
                locked <= 1'b0;
                run    <= 4'd0;
                exp_q  <= din + 8'd1;
              end else begin
                exp_q <= exp_q + 8'd1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
      if (clear) begin
        err_flag <= 1'b0;
        err_cnt  <= 8'd0;
      end
    end
  end

`ifdef CNT_STREAM_CHECKER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      good_cnt <= 16'd0;
    else if (clear)
      good_cnt <= 16'd0;
    else if (din_valid && (state == LOCKED) && match)
      good_cnt <= good_cnt + 16'd1;
  end
`else
  assign good_cnt = 16'd0;
`endif

endmodule
